// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C command arbiter: FSM encoding,
// command layout, well-known slave addresses and transfer result codes.
package i2c_cfg_pkg;

  localparam int CMD_W = 24;

  localparam logic [7:0] SLV_AUDIO_CODEC = 8'h34;
  localparam logic [7:0] SLV_VIDEO_DEC   = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_END = 3'd2,
    S_RELEASE  = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_NACK    = 2'd1,
    RES_TIMEOUT = 2'd2
  } result_t;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick_n.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping N-1 -> 0. Returns one-hot grant, its index and a valid flag.
module rr_pick_n #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = IW'((int'(ptr) + i) % N);
      if (!vld && req[pos]) begin
        vld      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C write engine between N_REQ requesters: round-robin grant,
// GO/END handshake, NACK retry, WAIT_END timeout and enforced bus-free gap.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | no owner; pick next requester round-robin, latch command
//   S_LOAD     | raise GO, clear timeout counter
//   S_WAIT_END | count cycles until END or timeout, then drop GO
//   S_RELEASE  | wait for END low; issue done/err or schedule a retry
//   S_GAP      | GAP_CYC cycles with GO low; back to LOAD on retry else IDLE
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int GAP_CYC     = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [N_REQ-1:0]       iREQ,
  input  logic [CMD_W*N_REQ-1:0] iREQ_DATA,
  output logic [N_REQ-1:0]       oGNT,
  output logic [N_REQ-1:0]       oDONE,
  output logic [N_REQ-1:0]       oERR,
  output logic [CMD_W-1:0]       oI2C_DATA,
  output logic                   oI2C_GO,
  input  logic                   iI2C_END,
  input  logic                   iI2C_ACK,
  output logic                   oBUSY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

  state_t            state, state_d;
  result_t           res, res_d;
  logic [IW-1:0]     ptr, ptr_d, owner, owner_d, pick_idx;
  logic [N_REQ-1:0]  pick_gnt, gnt_d, done_d, err_d;
  logic              pick_vld, go_d;
  logic [CMD_W-1:0]  data_d;
  logic [3:0]        retry, retry_d;
  logic [TW-1:0]     tmo, tmo_d;
  logic [GW-1:0]     gap, gap_d;

  rr_pick_n #(.N(N_REQ), .IW(IW)) u_pick (
    .req (iREQ),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign oBUSY = (state != S_IDLE);

  always_comb begin
    state_d = state;
    res_d   = res;
    ptr_d   = ptr;
    owner_d = owner;
    gnt_d   = oGNT;
    done_d  = '0;
    err_d   = '0;
    go_d    = oI2C_GO;
    data_d  = oI2C_DATA;
    retry_d = retry;
    tmo_d   = tmo;
    gap_d   = gap;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          gnt_d   = pick_gnt;
          data_d  = iREQ_DATA[int'(pick_idx)*CMD_W +: CMD_W];
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        go_d    = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        // END is checked first so a completion on the expiry cycle still counts
        if (iI2C_END) begin
          go_d    = 1'b0;
          res_d   = iI2C_ACK ? RES_NACK : RES_OK;
          state_d = S_RELEASE;
        end else if (tmo == TMO_LAST) begin
          go_d    = 1'b0;
          res_d   = RES_TIMEOUT;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!iI2C_END) begin
          gap_d   = '0;
          state_d = S_GAP;
          if (res == RES_NACK && retry < RETRY_MAX) begin
            retry_d = retry + 1'b1;
          end else begin
            if (res == RES_OK) done_d = oGNT;
            else               err_d  = oGNT;
            gnt_d = '0;
            ptr_d = (owner == IDX_LAST) ? '0 : owner + 1'b1;
          end
        end
      end
      S_GAP: begin
        // a retained grant means a retry is pending
        if (gap == GAP_LAST) state_d = (|oGNT) ? S_LOAD : S_IDLE;
        else                 gap_d   = gap + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= S_IDLE;
      res       <= RES_OK;
      ptr       <= '0;
      owner     <= '0;
      oGNT      <= '0;
      oDONE     <= '0;
      oERR      <= '0;
      oI2C_GO   <= 1'b0;
      oI2C_DATA <= '0;
      retry     <= '0;
      tmo       <= '0;
      gap       <= '0;
    end else begin
      state     <= state_d;
      res       <= res_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      oGNT      <= gnt_d;
      oDONE     <= done_d;
      oERR      <= err_d;
      oI2C_GO   <= go_d;
      oI2C_DATA <= data_d;
      retry     <= retry_d;
      tmo       <= tmo_d;
      gap       <= gap_d;
    end
  end

endmodule
